// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box, combinational byte substitution
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  // Row i of the table holds entries 16*i .. 16*i+15, entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  always_comb begin
    w_base = 11'd2047 - {i_in, 3'b000};
    o_out  = SBOX[w_base -: 8];
  end

endmodule

// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128 encryption, one transformation per cycle
// Round keys are expanded on the fly; bits [127:120] carry byte 0.
module aes_encrypt_core (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_PT,
  output logic         AES_DONE,
  output logic         AES_BUSY,
  output logic [127:0] AES_MSG_ENC
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT_ARK, S_SUB, S_SHIFT, S_MIX, S_KEY, S_ARK, S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [127:0]   r_st;
  logic [127:0]   r_rk;
  logic [3:0]     r_rnd;
  logic [7:0]     r_rcon;
  logic [127:0]   r_ct;

  logic [127:0]   w_sub;
  logic [31:0]    w_rot;
  logic [31:0]    w_subword;
  logic [127:0]   w_rk_nxt;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the state rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_subbytes
    aes_sbox u_sbox (
      .i_in  (r_st[8*g +: 8]),
      .o_out (w_sub[8*g +: 8])
    );
  end

  assign w_rot = {r_rk[23:0], r_rk[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_in  (w_rot[8*g +: 8]),
      .o_out (w_subword[8*g +: 8])
    );
  end

  always_comb begin
    w_rk_nxt          = '0;
    w_rk_nxt[127:96]  = r_rk[127:96] ^ w_subword ^ {r_rcon, 24'h000000};
    w_rk_nxt[95:64]   = r_rk[95:64]  ^ w_rk_nxt[127:96];
    w_rk_nxt[63:32]   = r_rk[63:32]  ^ w_rk_nxt[95:64];
    w_rk_nxt[31:0]    = r_rk[31:0]   ^ w_rk_nxt[63:32];
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    AES_DONE    = 1'b0;
    AES_BUSY    = 1'b1;
    case (r_state)
      S_IDLE: begin
        AES_BUSY = 1'b0;
        if (AES_START) w_state_nxt = S_LOAD;
      end
      S_LOAD:     w_state_nxt = S_INIT_ARK;
      S_INIT_ARK: w_state_nxt = S_SUB;
      S_SUB:      w_state_nxt = S_SHIFT;
      S_SHIFT:    w_state_nxt = (r_rnd == 4'd10) ? S_KEY : S_MIX;
      S_MIX:      w_state_nxt = S_KEY;
      S_KEY:      w_state_nxt = S_ARK;
      S_ARK:      w_state_nxt = (r_rnd == 4'd10) ? S_DONE : S_SUB;
      S_DONE: begin
        AES_DONE = 1'b1;
        AES_BUSY = 1'b0;
        if (!AES_START) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_st   <= '0;
      r_rk   <= '0;
      r_rnd  <= '0;
      r_rcon <= 8'h01;
      r_ct   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_st   <= AES_MSG_PT;
          r_rk   <= AES_KEY;
          r_rnd  <= 4'd1;
          r_rcon <= 8'h01;
        end
        S_INIT_ARK: r_st <= r_st ^ r_rk;
        S_SUB:      r_st <= w_sub;
        S_SHIFT:    r_st <= shift_rows(r_st);
        S_MIX:      r_st <= mix_columns(r_st);
        S_KEY: begin
          r_rk   <= w_rk_nxt;
          r_rcon <= xtime(r_rcon);
        end
        S_ARK: begin
          r_st <= r_st ^ r_rk;
          if (r_rnd == 4'd10) r_ct  <= r_st ^ r_rk;
          else                r_rnd <= r_rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign AES_MSG_ENC = r_ct;

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
AES-128 encryption core. It is the transmit-side counterpart of the team's AES decryption core and produces ciphertext that the decryption core accepts unchanged. It is an iterative, multi-cycle datapath with one AES transformation per cycle. The round keys are expanded on the fly, one per round, so the block holds no precomputed key schedule. It uses the same start/done handshake and 128-bit byte ordering as the decryption core, so it drops into the same Avalon wrapper.

Parameters:
None. The block is AES-128 only; the round count is fixed at 10 and the key is fixed at 128 bits.

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
AES_START  input  1  level request to encrypt; sampled only in IDLE
AES_KEY  input  128  cipher key; sampled only in LOAD
AES_MSG_PT  input  128  plaintext block; sampled only in LOAD
AES_DONE  output  1  high while in DONE
AES_BUSY  output  1  high in every state except IDLE and DONE
AES_MSG_ENC  output  128  registered ciphertext; updated only on entry to DONE

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Byte order: bits [127:120] hold byte 0, the first FIPS-197 input byte. Column c occupies bits [127-32c : 96-32c], and bytes are column-major within a column.
- Internal registers:
  - st (128 bits): working state.
  - rk (128 bits): current round key.
  - rnd (4 bits): round counter.
  - rcon (8 bits): round constant.
  - ct (128 bits): drives AES_MSG_ENC.
- Leaf S-box: a combinational 8-bit forward S-box module, with the FIPS-197 table in its own file.
  - 16 instances serve SubBytes.
  - 4 instances serve SubWord in the key step.
- Reset values: FSM = IDLE, AES_DONE = 0, AES_BUSY = 0, AES_MSG_ENC = 0, st = 0, rk = 0, rnd = 0, rcon = 8'h01. Reset mid-operation abandons the block and returns to IDLE with these values.
- FSM states and transitions:
  - IDLE: if AES_START is high, go to LOAD.
  - LOAD: st <= AES_MSG_PT, rk <= AES_KEY, rnd <= 1, rcon <= 01. Go to INIT_ARK.
  - INIT_ARK: st <= st ^ rk. Go to SUB.
  - SUB: st <= SubBytes(st). Go to SHIFT.
  - SHIFT: st <= ShiftRows(st), where row r rotates left by r bytes. If rnd == 10 go to KEY; otherwise go to MIX.
  - MIX: st <= MixColumns(st), per column, using GF(2^8) xtime with reduction polynomial 0x11B. Go to KEY.
  - KEY: rk <= next round key.
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
    - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
    - rcon <= xtime(rcon), giving the sequence 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
    - Go to ARK.
  - ARK: st <= st ^ rk. If rnd == 10, ct <= st ^ rk and go to DONE. Otherwise rnd <= rnd + 1 and go to SUB.
  - DONE: AES_DONE = 1. Stay while AES_START is high; go to IDLE when AES_START is low.
- Latency: START sampled high at edge E0 gives LOAD at E0 and DONE entered at E0+51.
  - Breakdown: 2 setup cycles + 9 full rounds × 5 cycles + 1 final round × 4 cycles.
  - AES_DONE is high from E0+51 until the edge after AES_START falls.
- Handshake rules:
  - AES_START is ignored outside IDLE and DONE. Deasserting it mid-operation does not abort.
  - AES_KEY and AES_MSG_PT may change after LOAD without effect.
  - AES_MSG_ENC holds the last ciphertext through IDLE and through the next operation until the next DONE entry.
- Back-to-back operation: if AES_START stays high continuously, the block stays in DONE and does not restart. A new operation requires AES_START low for at least one cycle, then high.
- rnd never exceeds 10. rcon wraps only through the xtime reduction (80 → 1B).

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → AES_MSG_ENC = 69c4e0d86a7b0430d8cdb78070b4c55a, with AES_DONE rising exactly 51 cycles after LOAD entry.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32. Also check internally that round-10 rk = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key and pt → ct 66e94bd4ef8a2c3b884cfa59ca342b2e. Hold AES_START high for 20 extra cycles after DONE → no restart and AES_DONE stays 1. Drop AES_START → IDLE next cycle, with AES_MSG_ENC retained.
- Assert RESET for one cycle at round 5 → next cycle FSM = IDLE, AES_MSG_ENC = 0, AES_BUSY = 0. Then rerun C.1 → correct ct.
- Change AES_KEY and AES_MSG_PT to random values every cycle after LOAD → ct still matches the vector latched at LOAD. Pulse AES_START mid-run → no effect.
- Loopback: feed each ciphertext into the AES decryption core with the same key → the recovered plaintext equals the original for 100 random key/pt pairs.
